// File: rtl/apb_ucpd_pkg.sv
// Shared constants for the UCPD status/interrupt stage: SR bit indices,
// field widths and the sticky/level split of the status register.
package apb_ucpd_pkg;

   localparam int SR_W    = 13;
   localparam int TX_ST_W = 7;
   localparam int RX_ST_W = 6;

   localparam int SR_TXIS      = 0;
   localparam int SR_TXMSGDISC = 1;
   localparam int SR_TXMSGSENT = 2;
   localparam int SR_TXMSGABT  = 3;
   localparam int SR_HRSTDISC  = 4;
   localparam int SR_HRSTSENT  = 5;
   localparam int SR_TXUND     = 6;
   localparam int SR_RXNE      = 7;
   localparam int SR_RXORDDET  = 8;
   localparam int SR_RXHRSTDET = 9;
   localparam int SR_RXOVR     = 10;
   localparam int SR_RXMSGEND  = 11;
   localparam int SR_RXERR     = 12;

   // TXIS and RXNE follow their inputs; every other bit latches on a rising edge.
   localparam logic [SR_W-1:0] SR_STICKY_MASK = 13'h1F7E;

   function automatic logic is_sticky(input int idx);
      return SR_STICKY_MASK[idx];
   endfunction

endpackage

// File: rtl/apb_ucpd_evt_flag.sv
// One sticky event flag: input history, rising-edge detect and a
// set-over-clear flag that is held cleared while the block is disabled.
module apb_ucpd_evt_flag (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic evt_in,
   input  logic clr,
   output logic flag
);

   logic hist_q;
   logic flag_q;
   logic rise;
   logic flag_d;

   assign rise = evt_in & ~hist_q;

   // A clear arriving in the same cycle as a new edge must not lose the event.
   always_comb begin
      flag_d = flag_q;
      if (!en) begin
         flag_d = 1'b0;
      end else if (rise) begin
         flag_d = 1'b1;
      end else if (clr) begin
         flag_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= 1'b0;
         flag_q <= 1'b0;
      end else begin
         hist_q <= en ? evt_in : 1'b0;
         flag_q <= flag_d;
      end
   end

   assign flag = flag_q;

endmodule

// File: rtl/apb_ucpd_irq_ctrl.sv
// UCPD status/interrupt stage: maps core TX/RX events into SR, keeps sticky
// flags with ICR write-1-to-clear, and masks SR with IMR onto ucpd_int.
module apb_ucpd_irq_ctrl
   import apb_ucpd_pkg::*;
#(
   parameter bit INT_REG = 1'b1
) (
   input  logic               ic_clk,
   input  logic               ic_rst_n,
   input  logic               ucpden,
   input  logic [TX_ST_W-1:0] tx_status,
   input  logic [RX_ST_W-1:0] rx_status,
   input  logic [SR_W-1:0]    imr,
   input  logic               icr_we,
   input  logic [SR_W-1:0]    icr_wdata,
   output logic [SR_W-1:0]    sr,
   output logic               ucpd_int
);

   logic [SR_W-1:0] evt_vec;
   logic            int_c;
   logic            unused_level_clr;

   assign evt_vec = {rx_status, tx_status};

   // Level bits have no clear path, so their ICR bits are intentionally dropped.
   assign unused_level_clr = icr_wdata[SR_TXIS] ^ icr_wdata[SR_RXNE];

   for (genvar i = 0; i < SR_W; i++) begin : g_sr
      if (is_sticky(i)) begin : g_sticky
         apb_ucpd_evt_flag u_flag (
            .clk    (ic_clk),
            .rst_n  (ic_rst_n),
            .en     (ucpden),
            .evt_in (evt_vec[i]),
            .clr    (icr_we & icr_wdata[i]),
            .flag   (sr[i])
         );
      end else begin : g_level
         logic lvl_q;

         always_ff @(posedge ic_clk or negedge ic_rst_n) begin
            if (!ic_rst_n) begin
               lvl_q <= 1'b0;
            end else begin
               lvl_q <= ucpden & evt_vec[i];
            end
         end

         assign sr[i] = lvl_q;
      end
   end

   assign int_c = |(sr & imr);

   if (INT_REG) begin : g_int_reg
      logic int_q;

      always_ff @(posedge ic_clk or negedge ic_rst_n) begin
         if (!ic_rst_n) begin
            int_q <= 1'b0;
         end else begin
            int_q <= int_c;
         end
      end

      assign ucpd_int = int_q;
   end else begin : g_int_comb
      assign ucpd_int = int_c;
   end

endmodule

// File: tb/tb_apb_ucpd_irq_ctrl.sv
// Bench for apb_ucpd_irq_ctrl: directed vector table, an async-reset sequence
// and randomized traffic against a vector-level reference model.
module tb_apb_ucpd_irq_ctrl;

   localparam logic [12:0] LEVEL_BITS = 13'h0081;

   logic        ic_clk = 1'b0;
   logic        ic_rst_n;
   logic        ucpden;
   logic [6:0]  tx_status;
   logic [5:0]  rx_status;
   logic [12:0] imr;
   logic        icr_we;
   logic [12:0] icr_wdata;
   logic [12:0] sr;
   logic        ucpd_int;
   logic [12:0] sr_c;
   logic        ucpd_int_c;

   int checks = 0;
   int errors = 0;

   logic [12:0] sr_m;
   logic [12:0] prev_m;
   logic        int_r_m;

   always #5 ic_clk = ~ic_clk;

   apb_ucpd_irq_ctrl #(.INT_REG(1'b1)) dut (
      .ic_clk(ic_clk), .ic_rst_n(ic_rst_n), .ucpden(ucpden),
      .tx_status(tx_status), .rx_status(rx_status), .imr(imr),
      .icr_we(icr_we), .icr_wdata(icr_wdata), .sr(sr), .ucpd_int(ucpd_int)
   );

   apb_ucpd_irq_ctrl #(.INT_REG(1'b0)) dut_c (
      .ic_clk(ic_clk), .ic_rst_n(ic_rst_n), .ucpden(ucpden),
      .tx_status(tx_status), .rx_status(rx_status), .imr(imr),
      .icr_we(icr_we), .icr_wdata(icr_wdata), .sr(sr_c), .ucpd_int(ucpd_int_c)
   );

   typedef struct {
      logic        en;
      logic [6:0]  tx;
      logic [5:0]  rx;
      logic [12:0] imr;
      logic        we;
      logic [12:0] wd;
      logic [12:0] sr;
      logic        ir;
      logic        ic;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic en, input logic [6:0] tx, input logic [5:0] rx,
                              input logic [12:0] im, input logic we, input logic [12:0] wd,
                              input logic [12:0] esr, input logic ir, input logic ic);
      vec_t r;
      r.en = en; r.tx = tx; r.rx = rx; r.imr = im; r.we = we; r.wd = wd;
      r.sr = esr; r.ir = ir; r.ic = ic;
      return r;
   endfunction

   task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: level bits copy the input, sticky bits latch on 0->1 of the
   // input vs. last enabled sample, clear via ICR unless a new edge arrives.
   task automatic model_edge();
      logic [12:0] in_v;
      in_v    = {rx_status, tx_status};
      int_r_m = |(sr_m & imr);
      if (!ucpden) begin
         sr_m   = '0;
         prev_m = '0;
      end else begin
         for (int b = 0; b < 13; b++) begin
            if (LEVEL_BITS[b])                 sr_m[b] = in_v[b];
            else if (in_v[b] && !prev_m[b])    sr_m[b] = 1'b1;
            else if (icr_we && icr_wdata[b])   sr_m[b] = 1'b0;
         end
         prev_m = in_v;
      end
   endtask

   task automatic cycle();
      @(posedge ic_clk);
      model_edge();
      @(negedge ic_clk);
   endtask

   task automatic chk_model();
      chk("sr", sr, sr_m);
      chk("sr_comb_inst", sr_c, sr_m);
      chk("int_reg", {12'b0, ucpd_int}, {12'b0, int_r_m});
      chk("int_comb", {12'b0, ucpd_int_c}, {12'b0, |(sr_m & imr)});
   endtask

   task automatic drive_idle();
      tx_status = '0; rx_status = '0; icr_we = 1'b0; icr_wdata = '0;
   endtask

   initial begin
      ic_rst_n = 1'b0;
      ucpden   = 1'b1;
      imr      = 13'h1FFF;
      drive_idle();
      sr_m = '0; prev_m = '0; int_r_m = 1'b0;

      // Directed sequence; expectations are after the edge that samples each row.
      tbl.push_back(v(1, 7'h04, 6'h00, 13'h1FFF, 0, 13'h0000, 13'h0004, 0, 1));
      tbl.push_back(v(1, 7'h00, 6'h00, 13'h1FFF, 0, 13'h0000, 13'h0004, 1, 1));
      tbl.push_back(v(1, 7'h00, 6'h00, 13'h1FFF, 1, 13'h0004, 13'h0000, 1, 0));
      tbl.push_back(v(1, 7'h00, 6'h00, 13'h1FFF, 0, 13'h0000, 13'h0000, 0, 0));
      tbl.push_back(v(1, 7'h04, 6'h00, 13'h1FFF, 0, 13'h0000, 13'h0004, 0, 1));
      tbl.push_back(v(1, 7'h04, 6'h00, 13'h1FFF, 1, 13'h0004, 13'h0000, 1, 0));
      tbl.push_back(v(1, 7'h04, 6'h00, 13'h1FFF, 0, 13'h0000, 13'h0000, 0, 0));
      tbl.push_back(v(1, 7'h00, 6'h00, 13'h1FFF, 0, 13'h0000, 13'h0000, 0, 0));
      tbl.push_back(v(1, 7'h00, 6'h10, 13'h1FFF, 1, 13'h0800, 13'h0800, 0, 1));
      tbl.push_back(v(1, 7'h00, 6'h00, 13'h1FFF, 1, 13'h0800, 13'h0000, 1, 0));
      tbl.push_back(v(1, 7'h00, 6'h00, 13'h1FFF, 0, 13'h0000, 13'h0000, 0, 0));
      tbl.push_back(v(1, 7'h00, 6'h04, 13'h0000, 0, 13'h0000, 13'h0200, 0, 0));
      tbl.push_back(v(1, 7'h00, 6'h00, 13'h0000, 0, 13'h0000, 13'h0200, 0, 0));
      tbl.push_back(v(1, 7'h00, 6'h00, 13'h0200, 0, 13'h0000, 13'h0200, 1, 1));
      tbl.push_back(v(1, 7'h00, 6'h00, 13'h1FFF, 1, 13'h0200, 13'h0000, 1, 0));
      tbl.push_back(v(1, 7'h00, 6'h00, 13'h1FFF, 0, 13'h0000, 13'h0000, 0, 0));
      tbl.push_back(v(1, 7'h01, 6'h01, 13'h1FFF, 0, 13'h0000, 13'h0081, 0, 1));
      tbl.push_back(v(1, 7'h01, 6'h01, 13'h1FFF, 1, 13'h0081, 13'h0081, 1, 1));
      tbl.push_back(v(1, 7'h00, 6'h00, 13'h1FFF, 0, 13'h0000, 13'h0000, 1, 0));
      tbl.push_back(v(1, 7'h00, 6'h00, 13'h1FFF, 0, 13'h0000, 13'h0000, 0, 0));
      tbl.push_back(v(1, 7'h7E, 6'h3E, 13'h1FFF, 0, 13'h0000, 13'h1F7E, 0, 1));
      tbl.push_back(v(1, 7'h00, 6'h00, 13'h1FFF, 0, 13'h0000, 13'h1F7E, 1, 1));
      tbl.push_back(v(0, 7'h00, 6'h00, 13'h1FFF, 0, 13'h0000, 13'h0000, 1, 0));
      tbl.push_back(v(0, 7'h00, 6'h00, 13'h1FFF, 0, 13'h0000, 13'h0000, 0, 0));
      tbl.push_back(v(0, 7'h04, 6'h00, 13'h1FFF, 0, 13'h0000, 13'h0000, 0, 0));
      tbl.push_back(v(1, 7'h04, 6'h00, 13'h1FFF, 0, 13'h0000, 13'h0004, 0, 1));
      tbl.push_back(v(1, 7'h00, 6'h00, 13'h1FFF, 1, 13'h0004, 13'h0000, 1, 0));
      tbl.push_back(v(1, 7'h00, 6'h00, 13'h1FFF, 0, 13'h0000, 13'h0000, 0, 0));

      #12;
      chk("reset_sr", sr, 13'h0000);
      chk("reset_int", {12'b0, ucpd_int}, 13'h0000);
      chk("reset_int_comb", {12'b0, ucpd_int_c}, 13'h0000);
      @(negedge ic_clk);
      ic_rst_n = 1'b1;

      foreach (tbl[i]) begin
         ucpden    = tbl[i].en;
         tx_status = tbl[i].tx;
         rx_status = tbl[i].rx;
         imr       = tbl[i].imr;
         icr_we    = tbl[i].we;
         icr_wdata = tbl[i].wd;
         cycle();
         chk($sformatf("vec%0d_sr", i), sr, tbl[i].sr);
         chk($sformatf("vec%0d_int", i), {12'b0, ucpd_int}, {12'b0, tbl[i].ir});
         chk($sformatf("vec%0d_int_comb", i), {12'b0, ucpd_int_c}, {12'b0, tbl[i].ic});
      end

      // Async reset in the middle of an event pulse with flags already set.
      drive_idle(); ucpden = 1'b1; imr = 13'h1FFF;
      tx_status = 7'h7E; rx_status = 6'h3E;
      cycle(); chk_model();
      drive_idle();
      cycle(); chk_model();
      tx_status = 7'h04;
      @(posedge ic_clk);
      #2;
      ic_rst_n = 1'b0;
      #1;
      chk("async_rst_sr", sr, 13'h0000);
      chk("async_rst_int", {12'b0, ucpd_int}, 13'h0000);
      chk("async_rst_int_comb", {12'b0, ucpd_int_c}, 13'h0000);
      sr_m = '0; prev_m = '0; int_r_m = 1'b0;
      tx_status = '0;
      @(negedge ic_clk);
      @(negedge ic_clk);
      chk("in_rst_sr", sr, 13'h0000);
      ic_rst_n = 1'b1;
      cycle(); chk_model();
      cycle(); chk_model();
      chk("no_replay_sr", sr, 13'h0000);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         ucpden    = ($urandom_range(0, 15) != 0);
         tx_status = 7'($urandom) & 7'($urandom);
         rx_status = 6'($urandom) & 6'($urandom);
         if ($urandom_range(0, 7) == 0) imr = 13'($urandom);
         icr_we    = ($urandom_range(0, 3) == 0);
         icr_wdata = 13'($urandom);
         cycle();
         chk_model();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
